// File: rtl/vec_modacc.sv
// vec_modacc: pops N-word vectors from a 1-write/N-read FIFO and sums
// count_i of them element-wise modulo MODULUS, then offers the result.
//
// Ports:
//   clk_i, reset_n_i       clock, synchronous active-low reset
//   start_i, count_i       job start and vector count (sampled in IDLE)
//   vec_i, vec_valid_i     FIFO parallel data / valid (word k = element k)
//   vec_yumi_o             FIFO pop request (valid AND state==ACCUM)
//   sum_o, sum_valid_o     accumulated vector, each element < MODULUS
//   sum_ready_i            downstream accept
//   busy_o                 high whenever not IDLE

`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif
`ifndef N_WRITE
`define N_WRITE 4
`endif

module vec_modacc #(
   parameter int BIT_WIDTH = `BIT_WIDTH,
   parameter int N         = `N_WRITE,
   parameter int MODULUS   = 2**BIT_WIDTH-5,
   parameter int CNT_W     = 8
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   start_i,
   input  logic [CNT_W-1:0]       count_i,
   input  logic [N*BIT_WIDTH-1:0] vec_i,
   input  logic                   vec_valid_i,
   output logic                   vec_yumi_o,
   output logic [N*BIT_WIDTH-1:0] sum_o,
   output logic                   sum_valid_o,
   input  logic                   sum_ready_i,
   output logic                   busy_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      OUT   = 2'd2
   } state_e;

   localparam logic [BIT_WIDTH:0] Q = (BIT_WIDTH+1)'(MODULUS);

   state_e                        state_q, state_d;
   logic [N-1:0][BIT_WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]              rem_q, rem_d;
   logic                          sum_valid_q, sum_valid_d;
   logic                          busy_q, busy_d;

   // One extra bit of headroom so a+b never overflows before the fold.
   function automatic logic [BIT_WIDTH-1:0] mod_add(
      input logic [BIT_WIDTH-1:0] a,
      input logic [BIT_WIDTH-1:0] b
   );
      logic [BIT_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= Q) s = s - Q;
      return s[BIT_WIDTH-1:0];
   endfunction

   assign vec_yumi_o = vec_valid_i && (state_q == ACCUM);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               acc_d = '0;
               rem_d = count_i;
               state_d = (count_i == '0) ? OUT : ACCUM;
            end
         end
         ACCUM: begin
            if (vec_valid_i) begin
               for (int k = 0; k < N; k++) begin
                  acc_d[k] = mod_add(acc_q[k],
                                     vec_i[k*BIT_WIDTH +: BIT_WIDTH]);
               end
               rem_d = rem_q - 1'b1;
               if (rem_q == CNT_W'(1)) state_d = OUT;
            end
         end
         OUT: begin
            if (sum_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Output flags are registered decodes of the next state.
      sum_valid_d = (state_d == OUT);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         rem_q       <= '0;
         sum_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         rem_q       <= rem_d;
         sum_valid_q <= sum_valid_d;
         busy_q      <= busy_d;
      end
   end

   // acc_q is frozen in OUT, so it doubles as the held result register.
   assign sum_o       = acc_q;
   assign sum_valid_o = sum_valid_q;
   assign busy_o      = busy_q;

endmodule
